// File: rtl/ifid_pipe_queue_if.sv
// ----------------------------------------------------------------------------
// ifid_pipe_queue_if
// Bundles the fetch-side and decode-side handshake of the IF->ID queue stage.
//   Fetch side : if_valid, if_inst, if_pc (to stage), if_ready (from stage)
//   Decode side: id_valid, id_inst, id_pc (from stage), id_ready (to stage)
//   Control    : flush (to stage), count (occupancy, from stage)
// Modports:
//   slave  - the queue stage itself
//   master - the environment (fetch unit + decoder + redirect logic)
// Parameters must match the ones given to ifid_pipe_queue.
// ----------------------------------------------------------------------------
interface ifid_pipe_queue_if #(
    parameter int INST_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2
) ();
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              if_valid;
    logic [INST_W-1:0] if_inst;
    logic [ADDR_W-1:0] if_pc;
    logic              if_ready;
    logic              id_valid;
    logic [INST_W-1:0] id_inst;
    logic [ADDR_W-1:0] id_pc;
    logic              id_ready;
    logic              flush;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  if_valid, if_inst, if_pc, id_ready, flush,
        output if_ready, id_valid, id_inst, id_pc, count
    );

    modport master (
        output if_valid, if_inst, if_pc, id_ready, flush,
        input  if_ready, id_valid, id_inst, id_pc, count
    );
endinterface

// File: rtl/ifid_pipe_queue.sv
// ----------------------------------------------------------------------------
// ifid_pipe_queue
// IF->ID pipeline stage holding up to DEPTH (inst, pc) pairs in order.
// First-word fall-through on the decode side; empty slots appear as NOP bubbles.
// A flush empties the stage in one cycle and drops the same-cycle fetch beat.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - ifid_pipe_queue_if.slave (fetch/decode handshakes, flush, count)
// Optional build macro:
//   IFID_POST_FLUSH_KILL_EN - after a flush, the first accepted fetch beat is
//   squashed (delay-slot kill). Without it, that beat is stored normally.
// ----------------------------------------------------------------------------
module ifid_pipe_queue #(
    parameter int                INST_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [INST_W-1:0] NOP_INST = {INST_W{1'b0}}
) (
    input  logic                clk,
    input  logic                rst_n,
    ifid_pipe_queue_if.slave    bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    logic full_s;
    logic empty_s;
    logic push_s;
    logic pop_s;
    logic store_s;

    // Full: same slot index, opposite wrap bit. Empty: pointers identical.
    assign full_s  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign empty_s = (wr_ptr_q == rd_ptr_q);

    // if_ready depends on occupancy only, so a pop at full does not reopen it
    // until the following cycle.
    assign push_s = bus.if_valid & ~full_s & ~bus.flush;
    assign pop_s  = ~empty_s & bus.id_ready & ~bus.flush;

    assign bus.if_ready = ~full_s;
    assign bus.id_valid = ~empty_s;
    assign bus.count    = wr_ptr_q - rd_ptr_q;
    assign bus.id_inst  = empty_s ? NOP_INST : inst_mem_q[rd_ptr_q[IDX_W-1:0]];
    assign bus.id_pc    = empty_s ? {ADDR_W{1'b0}} : pc_mem_q[rd_ptr_q[IDX_W-1:0]];

`ifdef IFID_POST_FLUSH_KILL_EN
    logic kill_q, kill_d;

    // Squash the first accepted beat after a flush; flag persists until then.
    always_comb begin
        kill_d  = kill_q;
        store_s = push_s;
        if (bus.flush) begin
            kill_d = 1'b1;
        end else if (push_s && kill_q) begin
            kill_d  = 1'b0;
            store_s = 1'b0;
        end else begin
            kill_d = kill_q;
        end
    end

    // Kill flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kill_q <= 1'b0;
        end else begin
            kill_q <= kill_d;
        end
    end
`else
    assign store_s = push_s;
`endif

    // Pointer next-state: flush re-aligns read onto write, discarding contents.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (bus.flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, store_s};
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop_s};
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents need no reset because occupancy gates the outputs.
    always_ff @(posedge clk) begin
        if (store_s) begin
            inst_mem_q[wr_ptr_q[IDX_W-1:0]] <= bus.if_inst;
            pc_mem_q[wr_ptr_q[IDX_W-1:0]]   <= bus.if_pc;
        end
    end
endmodule

// File: tb/tb_ifid_pipe_queue.sv
// ----------------------------------------------------------------------------
// tb_ifid_pipe_queue
// Drives identical fetch/decode stimulus into a DEPTH=2 and a DEPTH=4 instance
// and compares every observable output each cycle against a queue-based model.
// ----------------------------------------------------------------------------
module tb_ifid_pipe_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ifid_pipe_queue_if #(.INST_W(32), .ADDR_W(32), .DEPTH(2)) b2 ();
    ifid_pipe_queue_if #(.INST_W(32), .ADDR_W(32), .DEPTH(4)) b4 ();

    ifid_pipe_queue #(.INST_W(32), .ADDR_W(32), .DEPTH(2), .NOP_INST(NOP)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );
    ifid_pipe_queue #(.INST_W(32), .ADDR_W(32), .DEPTH(4), .NOP_INST(NOP)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4)
    );

    logic        in_valid, in_ready, in_flush;
    logic [31:0] in_inst, in_pc;

    assign b2.if_valid = in_valid;
    assign b2.if_inst  = in_inst;
    assign b2.if_pc    = in_pc;
    assign b2.id_ready = in_ready;
    assign b2.flush    = in_flush;
    assign b4.if_valid = in_valid;
    assign b4.if_inst  = in_inst;
    assign b4.if_pc    = in_pc;
    assign b4.id_ready = in_ready;
    assign b4.flush    = in_flush;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one in-order queue of {inst, pc} per instance.
    logic [63:0] mq [2][$];
    int          dep [2] = '{2, 4};
    bit          kl  [2] = '{1'b0, 1'b0};

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_side(string nm, int i, logic [31:0] cnt, logic vld, logic rdy,
                              logic [31:0] inst, logic [31:0] pc);
        int          sz;
        logic [63:0] head;
        sz   = mq[i].size();
        head = (sz != 0) ? mq[i][0] : 64'h0;
        chk({nm, " count"},    cnt, 32'(sz));
        chk({nm, " id_valid"}, {31'b0, vld}, {31'b0, (sz != 0)});
        chk({nm, " if_ready"}, {31'b0, rdy}, {31'b0, (sz != dep[i])});
        chk({nm, " id_inst"},  inst, (sz != 0) ? head[63:32] : NOP);
        chk({nm, " id_pc"},    pc,   (sz != 0) ? head[31:0]  : 32'h0);
    endtask

    task automatic check_all();
        check_side("d2", 0, 32'(b2.count), b2.id_valid, b2.if_ready, b2.id_inst, b2.id_pc);
        check_side("d4", 1, 32'(b4.count), b4.id_valid, b4.if_ready, b4.id_inst, b4.id_pc);
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (in_flush) begin
                mq[i].delete();
`ifdef IFID_POST_FLUSH_KILL_EN
                kl[i] = 1'b1;
`endif
            end else begin
                bit rdy, pop, push;
                rdy  = (mq[i].size() != dep[i]);
                pop  = (mq[i].size() != 0) && in_ready;
                push = in_valid && rdy;
                if (pop) void'(mq[i].pop_front());
                if (push) begin
                    if (kl[i]) kl[i] = 1'b0;
                    else       mq[i].push_back({in_inst, in_pc});
                end
            end
        end
    endtask

    task automatic step(bit v, logic [31:0] pc, bit r, bit f);
        @(negedge clk);
        in_valid = v;
        in_pc    = pc;
        in_inst  = $urandom;
        in_ready = r;
        in_flush = f;
        #1;
        check_all();
        model_update();
    endtask

    initial begin
        logic [31:0] pc;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_ready = 1'b0;
        in_flush = 1'b0;
        in_inst  = 32'h0;
        in_pc    = 32'h0;
        #12;
        check_all();
        rst_n = 1'b1;

        // Fill with decoder stalled, then drain.
        step(1'b1, 32'h100, 1'b0, 1'b0);
        step(1'b1, 32'h104, 1'b0, 1'b0);
        step(1'b1, 32'h108, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming: one push and one pop per cycle.
        for (int i = 0; i < 8; i++) step(1'b1, 32'(i * 4), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush with a same-cycle fetch beat, then consecutive flushes.
        step(1'b1, 32'h180, 1'b0, 1'b0);
        step(1'b1, 32'h184, 1'b0, 1'b0);
        step(1'b1, 32'h200, 1'b1, 1'b1);
        step(1'b0, 32'h0,   1'b1, 1'b0);
        step(1'b1, 32'h210, 1'b1, 1'b1);
        step(1'b1, 32'h214, 1'b1, 1'b1);
        step(1'b0, 32'h0,   1'b0, 1'b0);

        // Post-flush beats: squash depends on build configuration.
        step(1'b0, 32'h0,   1'b0, 1'b1);
        step(1'b0, 32'h0,   1'b0, 1'b0);
        step(1'b1, 32'h300, 1'b0, 1'b0);
        step(1'b1, 32'h304, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges with two entries held.
        step(1'b1, 32'h400, 1'b0, 1'b0);
        step(1'b1, 32'h404, 1'b0, 1'b0);
        step(1'b0, 32'h0,   1'b0, 1'b1);
        step(1'b1, 32'h408, 1'b0, 1'b0);
        step(1'b1, 32'h40c, 1'b0, 1'b0);
        step(1'b0, 32'h0,   1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            kl[i] = 1'b0;
        end
        check_all();
        #1;
        rst_n = 1'b1;
        step(1'b1, 32'h500, 1'b1, 1'b0);
        step(1'b1, 32'h504, 1'b1, 1'b0);

        // Randomized traffic with occasional flushes.
        pc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, pc, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0);
            pc = pc + 32'd4;
        end

        @(negedge clk);
        #1;
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
